// File: rtl/fpu_pkg.sv
// +--------------------------------------------------------------------+
// | fpu_pkg : format constants, status indices and FSM states for fpu  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;
  localparam int SIG_W  = MANT_W + 1;   // hidden bit + stored mantissa
  localparam int WRK_W  = SIG_W + 3;    // significand + guard/round/sticky
  localparam int LZC_W  = SIG_W + 1;    // significand + guard

  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;

  typedef logic [2:0] state_t;

  localparam state_t S_LOAD  = 3'd0;
  localparam state_t S_ALIGN = 3'd1;
  localparam state_t S_ADD   = 3'd2;
  localparam state_t S_NORM  = 3'd3;
  localparam state_t S_ROUND = 3'd4;
  localparam state_t S_WRITE = 3'd5;

endpackage

`default_nettype wire

// File: rtl/fpu_lzc.sv
// +--------------------------------------------------------------------+
// | fpu_lzc : leading-zero count of the 27-bit significand+guard field |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fpu_lzc
  import fpu_pkg::*;
(
  input  logic [LZC_W-1:0] i_value,
  output logic [4:0]       o_count
);

  always_comb begin
    o_count = 5'(LZC_W);
    for (int i = 0; i < LZC_W; i++) begin
      if (i_value[i]) o_count = 5'(LZC_W - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu.sv
// +--------------------------------------------------------------------+
// | fpu : six-cycle free-running adder/subtractor, custom 32-bit float |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fpu
  import fpu_pkg::*;
(
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [31:0] op_A_in,
  input  logic [31:0] op_B_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  state_t              r_state;
  logic [31:0]         r_op_a, r_op_b;
  logic [WRK_W-1:0]    r_big, r_small, r_norm;
  logic [WRK_W:0]      r_sum;
  logic signed [7:0]   r_exp;
  logic [MANT_W-1:0]   r_mant;
  logic                r_sign, r_sub, r_special, r_zero, r_inexact;

  logic [EXP_W-1:0]    w_exp_a, w_exp_b, w_exp_big, w_exp_small, w_diff;
  logic [SIG_W-1:0]    w_sig_a, w_sig_b, w_sig_big, w_sig_small;
  logic                w_a_big, w_lost, w_round_up;
  logic [WRK_W-1:0]    w_small_ext, w_shifted, w_aligned;
  logic [4:0]          w_lz;
  logic [SIG_W:0]      w_rounded;
  logic [31:0]         w_data;
  logic [3:0]          w_status;

  // Exponent zero flushes the operand to zero regardless of its mantissa.
  assign w_exp_a = r_op_a[30:25];
  assign w_exp_b = r_op_b[30:25];
  assign w_sig_a = (w_exp_a == '0) ? '0 : {1'b1, r_op_a[MANT_W-1:0]};
  assign w_sig_b = (w_exp_b == '0) ? '0 : {1'b1, r_op_b[MANT_W-1:0]};
  assign w_a_big = {w_exp_a, w_sig_a} >= {w_exp_b, w_sig_b};

  assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
  assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
  assign w_sig_big   = w_a_big ? w_sig_a : w_sig_b;
  assign w_sig_small = w_a_big ? w_sig_b : w_sig_a;
  assign w_diff      = w_exp_big - w_exp_small;

  assign w_small_ext = {w_sig_small, 3'b000};
  assign w_shifted   = w_small_ext >> w_diff;
  assign w_lost      = |(w_small_ext & ~({WRK_W{1'b1}} << w_diff));

  always_comb begin
    w_aligned = {w_shifted[WRK_W-1:1], w_shifted[0] | w_lost};
    if (w_diff > 6'd27) w_aligned = {{(WRK_W-1){1'b0}}, |w_sig_small};
  end

  // Only sum[28:2] can carry leading zeros that matter; G/R/S ride along.
  fpu_lzc u_lzc (
    .i_value (r_sum[WRK_W-1:2]),
    .o_count (w_lz)
  );

  assign w_round_up = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
  assign w_rounded  = {1'b0, r_norm[WRK_W-1:3]} + (SIG_W + 1)'(w_round_up);

  always_comb begin
    w_data   = '0;
    w_status = '0;
    if (r_special || (!r_zero && r_exp >= 8'sd63)) begin
      w_data                = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      w_status[ST_OVERFLOW] = 1'b1;
    end else if (r_zero) begin
      w_status[ST_EXACT] = 1'b1;
    end else if (r_exp <= 8'sd0) begin
      w_status[ST_UNDERFLOW] = 1'b1;
    end else begin
      w_data = {r_sign, r_exp[EXP_W-1:0], r_mant};
      if (r_inexact) w_status[ST_INEXACT] = 1'b1;
      else           w_status[ST_EXACT]   = 1'b1;
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state    <= S_LOAD;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_big      <= '0;
      r_small    <= '0;
      r_sum      <= '0;
      r_norm     <= '0;
      r_exp      <= '0;
      r_mant     <= '0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_special  <= 1'b0;
      r_zero     <= 1'b0;
      r_inexact  <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_op_a  <= op_A_in;
          r_op_b  <= op_B_in;
          r_state <= S_ALIGN;
        end
        S_ALIGN: begin
          r_big     <= {w_sig_big, 3'b000};
          r_small   <= w_aligned;
          r_exp     <= $signed({2'b00, w_exp_big});
          r_sign    <= w_a_big ? r_op_a[31] : r_op_b[31];
          r_sub     <= r_op_a[31] ^ r_op_b[31];
          r_special <= (w_exp_a == {EXP_W{1'b1}}) || (w_exp_b == {EXP_W{1'b1}});
          r_state   <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                           : ({1'b0, r_big} + {1'b0, r_small});
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_zero <= (r_sum == '0);
          if (r_sum[WRK_W]) begin
            r_norm <= {r_sum[WRK_W:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + 8'sd1;
          end else begin
            r_norm <= r_sum[WRK_W-1:0] << w_lz;
            r_exp  <= r_exp - $signed({3'b000, w_lz});
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_inexact <= |r_norm[2:0];
          if (w_rounded[SIG_W]) begin
            r_mant <= w_rounded[MANT_W:1];
            r_exp  <= r_exp + 8'sd1;
          end else begin
            r_mant <= w_rounded[MANT_W-1:0];
          end
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          data_out   <= w_data;
          status_out <= w_status;
          r_state    <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu.sv
// Self-checking bench for fpu: random operands against an exact-integer
// reference, plus the directed boundary vectors and asynchronous reset.
`default_nettype none

module tb_fpu;

  logic        clock100KHz = 1'b0;
  logic        reset       = 1'b0;
  logic [31:0] op_A_in     = '0;
  logic [31:0] op_B_in     = '0;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] prev_d = '0;
  logic [3:0]  prev_s = '0;

  fpu dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .op_A_in     (op_A_in),
    .op_B_in     (op_B_in),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  always #5 clock100KHz = ~clock100KHz;

  // Operands are exact integers scaled by 2^56; sum exactly, then round to nearest even.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic [3:0] st);
    logic [127:0] va, vb, mag, keep, rem, half;
    logic         s;
    int           p, sh, e;
    va = (a[30:25] == 6'd0) ? 128'd0 : (128'({1'b1, a[24:0]}) << a[30:25]);
    vb = (b[30:25] == 6'd0) ? 128'd0 : (128'({1'b1, b[24:0]}) << b[30:25]);
    if (a[31] == b[31]) begin mag = va + vb; s = a[31]; end
    else if (va >= vb)  begin mag = va - vb; s = a[31]; end
    else                begin mag = vb - va; s = b[31]; end
    if (mag == 128'd0) begin d = 32'h0; st = 4'b0001; return; end
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    if (p < 26) begin d = 32'h0; st = 4'b0100; return; end
    sh   = p - 25;
    e    = sh;
    keep = mag >> sh;
    rem  = mag & ((128'd1 << sh) - 128'd1);
    half = 128'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
    if (keep[26]) begin keep = keep >> 1; e = e + 1; end
    if (e >= 63) begin d = {s, 6'h3f, 25'h0}; st = 4'b0010; return; end
    d  = {s, 6'(e), keep[24:0]};
    st = (rem != 128'd0) ? 4'b1000 : 4'b0001;
  endfunction

  task automatic drive_ops(input logic [31:0] a, input logic [31:0] b);
    op_A_in = a;
    op_B_in = b;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock100KHz);
    #1;
  endtask

  task automatic test_reset;
    drive_ops($urandom, $urandom);
    wait_cycles(3);
    vectors++;
    if (data_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: data_out=%h required %h", data_out, 32'h0);
    end
    vectors++;
    if (status_out !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_status: status_out=%b required %b", status_out, 4'b0000);
    end
    @(posedge clock100KHz);
    #1 reset = 1'b1;
    prev_d = '0;
    prev_s = '0;
  endtask

  task automatic test_random;
    logic [31:0] a, b, ed;
    logic [3:0]  es;
    int          ea, eb, dl;
    for (int n = 0; n < 60; n++) begin
      ea = int'($urandom_range(62, 1));
      if ($urandom_range(7, 0) == 0) ea = 0;
      dl = int'($urandom_range(6, 0));
      case ($urandom_range(3, 0))
        0:       eb = int'($urandom_range(62, 0));
        1:       eb = ea;
        default: eb = ea + dl - 3;
      endcase
      if (eb < 0)  eb = 0;
      if (eb > 62) eb = 62;
      a = {1'($urandom), 6'(ea), 25'($urandom)};
      b = {1'($urandom), 6'(eb), 25'($urandom)};
      if ($urandom_range(4, 0) == 0) b[24:0] = a[24:0];
      ref_add(a, b, ed, es);
      drive_ops(a, b);
      wait_cycles(5);
      vectors++;
      if (data_out !== prev_d || status_out !== prev_s) begin
        miscompares++;
        $display("FAIL random_hold: data_out=%h status_out=%b required %h %b",
                 data_out, status_out, prev_d, prev_s);
      end
      wait_cycles(1);
      vectors++;
      if (data_out !== ed || status_out !== es) begin
        miscompares++;
        $display("FAIL random_sum a=%h b=%h: data_out=%h status_out=%b required %h %b",
                 a, b, data_out, status_out, ed, es);
      end
      prev_d = ed;
      prev_s = es;
    end
  endtask

  task automatic test_directed;
    logic [31:0] va [6] = '{32'h15000000, 32'h3E000000, 32'h3E000000,
                            32'h7DFFFFFF, 32'h7E000000, 32'h02000001};
    logic [31:0] vb [6] = '{32'h15400000, 32'hBE000000, 32'h0A000000,
                            32'h7DFFFFFF, 32'h3E000000, 32'h82000000};
    logic [31:0] vd [6] = '{32'h17200000, 32'h00000000, 32'h3E000000,
                            32'h7E000000, 32'h7E000000, 32'h00000000};
    logic [3:0]  vs [6] = '{4'b0001, 4'b0001, 4'b1000, 4'b0010, 4'b0010, 4'b0100};
    for (int n = 0; n < 6; n++) begin
      drive_ops(va[n], vb[n]);
      wait_cycles(5);
      vectors++;
      if (data_out !== prev_d || status_out !== prev_s) begin
        miscompares++;
        $display("FAIL directed_hold_%0d: data_out=%h status_out=%b required %h %b",
                 n, data_out, status_out, prev_d, prev_s);
      end
      wait_cycles(1);
      vectors++;
      if (data_out !== vd[n] || status_out !== vs[n]) begin
        miscompares++;
        $display("FAIL directed_%0d a=%h b=%h: data_out=%h status_out=%b required %h %b",
                 n, va[n], vb[n], data_out, status_out, vd[n], vs[n]);
      end
      prev_d = vd[n];
      prev_s = vs[n];
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] a, b, ed;
    logic [3:0]  es;
    drive_ops(32'h15000000, 32'h15400000);
    wait_cycles(6);
    vectors++;
    if (data_out !== 32'h17200000 || status_out !== 4'b0001) begin
      miscompares++;
      $display("FAIL pre_reset_sum: data_out=%h status_out=%b required %h %b",
               data_out, status_out, 32'h17200000, 4'b0001);
    end
    wait_cycles(2);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (data_out !== 32'h0 || status_out !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset_clear: data_out=%h status_out=%b required %h %b",
               data_out, status_out, 32'h0, 4'b0000);
    end
    @(posedge clock100KHz);
    #1 reset = 1'b1;
    a = {1'b0, 6'd40, 25'($urandom)};
    b = {1'b1, 6'd38, 25'($urandom)};
    ref_add(a, b, ed, es);
    drive_ops(a, b);
    wait_cycles(5);
    vectors++;
    if (data_out !== 32'h0 || status_out !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_hold: data_out=%h status_out=%b required %h %b",
               data_out, status_out, 32'h0, 4'b0000);
    end
    wait_cycles(1);
    vectors++;
    if (data_out !== ed || status_out !== es) begin
      miscompares++;
      $display("FAIL post_reset_sum a=%h b=%h: data_out=%h status_out=%b required %h %b",
               a, b, data_out, status_out, ed, es);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_directed();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
